// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the fetch/data memory port arbiter
package mem_arb_pkg;
  localparam int AW_DEF = 17;
  localparam int DW_DEF = 32;
  localparam int STREAK_MAX_DEF = 4;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_e;
  typedef enum logic [1:0] {RSP_IDLE, RSP_IF, RSP_D} rsp_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and RAM-side signals of the memory port arbiter
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [3:0]    d_wea;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_ready;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wea;
  logic [DW-1:0] mem_rdata;
  modport slave (
    input  if_req, if_addr, d_req, d_addr, d_wdata, d_wea, mem_ready, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_addr, mem_wdata, mem_wea
  );
  modport master (
    output if_req, if_addr, d_req, d_addr, d_wdata, d_wea, mem_ready, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_addr, mem_wdata, mem_wea
  );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: data-priority winner select with a fetch starvation counter
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STREAK_MAX = STREAK_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       if_req,
  input  logic       d_req,
  input  logic       mem_ready,
  output logic       if_gnt,
  output logic       d_gnt,
  output logic [2:0] streak_cnt
);
  logic [2:0] streak_q, streak_d;
  logic       if_win;
  always_comb begin
    if_win = if_req && (!d_req || streak_q == 3'(STREAK_MAX));
    if_gnt = rst_n && mem_ready && if_win;
    d_gnt = rst_n && mem_ready && d_req && !if_win;
    // counts only D grants that made a waiting fetch wait longer
    streak_d = (!if_req || if_gnt) ? 3'd0 :
               (d_gnt && streak_q != 3'(STREAK_MAX)) ? streak_q + 3'd1 : streak_q;
    streak_cnt = streak_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) streak_q <= 3'd0;
    else streak_q <= streak_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one sync-read RAM between fetch and load/store requesters
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int STREAK_MAX = STREAK_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus,
  output logic [2:0]        streak_cnt
);
  logic          if_gnt, d_gnt;
  owner_e        own;
  rsp_e          rsp_q, rsp_d;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  mem_arb_pick #(.STREAK_MAX(STREAK_MAX)) u_pick (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (bus.if_req),
    .d_req      (bus.d_req),
    .mem_ready  (bus.mem_ready),
    .if_gnt     (if_gnt),
    .d_gnt      (d_gnt),
    .streak_cnt (streak_cnt)
  );
  always_comb begin
    own = if_gnt ? OWN_IF : d_gnt ? OWN_D : OWN_NONE;
    addr = own == OWN_IF ? bus.if_addr : bus.d_addr;
    wdata = own == OWN_IF ? '0 : bus.d_wdata;
    bus.if_gnt = if_gnt;
    bus.d_gnt = d_gnt;
    bus.mem_en = own != OWN_NONE;
    bus.mem_addr = addr;
    bus.mem_wdata = wdata;
    bus.mem_wea = own == OWN_D ? bus.d_wea : 4'd0;
    // fetches are always reads; a D access with any byte enable is a write
    rsp_d = own == OWN_IF ? RSP_IF :
            (own == OWN_D && bus.d_wea == 4'd0) ? RSP_D : RSP_IDLE;
    bus.if_rvalid = rsp_q == RSP_IF;
    bus.if_rdata = rsp_q == RSP_IF ? bus.mem_rdata : '0;
    bus.d_rvalid = rsp_q == RSP_D;
    bus.d_rdata = rsp_q == RSP_D ? bus.mem_rdata : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rsp_q <= RSP_IDLE;
    else rsp_q <= rsp_d;
endmodule
